// File: rtl/hilo_ctrl_if.sv
// Bundle between hilo_ctrl, the execute stage and the multi-cycle mul/div unit.
// slave is the controller's view; master is the environment (execute + unit).
interface hilo_ctrl_if;
    logic        issue;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  md_choice;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_rst;
    logic        md_busy;
    logic [31:0] md_q;
    logic [31:0] md_r;
    logic        md_err;

    modport master (
        output issue, op, rs_val, rt_val, md_busy, md_q, md_r,
        input  stall, hi, lo, md_choice, md_a, md_b, md_rst, md_err
    );

    modport slave (
        input  issue, op, rs_val, rt_val, md_busy, md_q, md_r,
        output stall, hi, lo, md_choice, md_a, md_b, md_rst, md_err
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register owner and sequencer for the multi-cycle mul/div unit.
// Latches requests, holds choice/operands stable and captures results into HI/LO.
module hilo_ctrl #(
    parameter int unsigned TIMEOUT = 48
) (
    input logic        clk,
    input logic        rst,
    hilo_ctrl_if.slave ctrl_io
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDstart, StDwait} state_e;

    state_e          state_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [3:0]      choice_q;
    logic [CntW-1:0] cnt_q;
    logic            abort_q;
    logic [3:0]      choice_dec;

    always_comb begin
        choice_dec = 4'b0000;
        unique case (ctrl_io.op)
            3'b001:  choice_dec = 4'b0010;
            3'b010:  choice_dec = 4'b0001;
            3'b011:  choice_dec = 4'b1000;
            3'b100:  choice_dec = 4'b0100;
            default: choice_dec = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            choice_q <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ctrl_io.issue) begin
                        if (choice_dec != 4'b0000) begin
                            a_q      <= ctrl_io.rs_val;
                            b_q      <= ctrl_io.rt_val;
                            choice_q <= choice_dec;
                            cnt_q    <= '0;
                            state_q  <= (choice_dec[1] | choice_dec[0]) ? StMul : StDstart;
                        end else if (ctrl_io.op == 3'b101) begin
                            hi_q <= ctrl_io.rs_val;
                        end else if (ctrl_io.op == 3'b110) begin
                            lo_q <= ctrl_io.rs_val;
                        end
                    end
                end
                StMul: begin
                    hi_q     <= ctrl_io.md_q;
                    lo_q     <= ctrl_io.md_r;
                    choice_q <= '0;
                    state_q  <= StIdle;
                end
                StDstart, StDwait: begin
                    // Timeout wins over a capture falling on the same edge.
                    if (cnt_q == CntLast) begin
                        choice_q <= '0;
                        abort_q  <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (state_q == StDstart) begin
                            if (ctrl_io.md_busy) state_q <= StDwait;
                        end else if (!ctrl_io.md_busy) begin
                            lo_q     <= ctrl_io.md_q;
                            hi_q     <= ctrl_io.md_r;
                            choice_q <= '0;
                            state_q  <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign ctrl_io.stall     = ctrl_io.issue & (state_q != StIdle);
    assign ctrl_io.hi        = hi_q;
    assign ctrl_io.lo        = lo_q;
    assign ctrl_io.md_choice = choice_q;
    assign ctrl_io.md_a      = a_q;
    assign ctrl_io.md_b      = b_q;
    assign ctrl_io.md_rst    = ~rst | abort_q;
    assign ctrl_io.md_err    = abort_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mul/div unit, transaction-level HI/LO model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_hilo_ctrl;
    localparam int unsigned TIMEOUT = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hilo_ctrl_if bus ();

    hilo_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    // Returns {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = a;
            sb = b;
            return {sa / sb, sa % sb};
        end
        return {a / b, a % b};
    endfunction

    // Unit model: multiply is combinational; divide starts once per choice assertion.
    int unsigned u_lat = 33;
    int unsigned u_cnt = 0;
    bit          u_done = 1'b0;
    logic [31:0] u_q = '0;
    logic [31:0] u_r = '0;

    always @(posedge clk) begin
        if (bus.md_rst) begin
            u_cnt  <= 0;
            u_done <= 1'b0;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
        end else if (bus.md_choice == 4'b0000) begin
            u_done <= 1'b0;
        end else if ((bus.md_choice == 4'b1000 || bus.md_choice == 4'b0100) && !u_done) begin
            u_cnt      <= u_lat;
            u_done     <= 1'b1;
            {u_q, u_r} <= ref_div(bus.md_choice == 4'b1000, bus.md_a, bus.md_b);
        end
    end

    assign bus.md_busy = (u_cnt != 0);

    always_comb begin
        bus.md_q = u_q;
        bus.md_r = u_r;
        if (bus.md_choice == 4'b0010)
            {bus.md_q, bus.md_r} = ref_mul(1'b1, bus.md_a, bus.md_b);
        else if (bus.md_choice == 4'b0001)
            {bus.md_q, bus.md_r} = ref_mul(1'b0, bus.md_a, bus.md_b);
    end

    // Reference model: pending operation (0 none, 1 multiply, 2 divide) and its age.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [3:0]  m_choice = '0;
    int          m_pend = 0;
    int          m_age = 0;
    bit          m_seen = 1'b0;
    bit          m_abort = 1'b0;

    function automatic logic [3:0] choice_of(input logic [2:0] op);
        case (op)
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0001;
            3'b011:  return 4'b1000;
            3'b100:  return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_choice = '0;
            m_pend = 0; m_age = 0; m_seen = 1'b0; m_abort = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (m_pend == 0) begin
                if (bus.issue) begin
                    if (choice_of(bus.op) != 4'b0000) begin
                        m_a      = bus.rs_val;
                        m_b      = bus.rt_val;
                        m_choice = choice_of(bus.op);
                        m_pend   = (bus.op <= 3'b010) ? 1 : 2;
                        m_age    = 0;
                        m_seen   = 1'b0;
                    end else if (bus.op == 3'b101) begin
                        m_hi = bus.rs_val;
                    end else if (bus.op == 3'b110) begin
                        m_lo = bus.rs_val;
                    end
                end
            end else if (m_pend == 1) begin
                {m_hi, m_lo} = ref_mul(m_choice == 4'b0010, m_a, m_b);
                m_pend = 0;
            end else if (m_age == TIMEOUT - 1) begin
                m_pend  = 0;
                m_abort = 1'b1;
            end else begin
                if (m_seen && !bus.md_busy) begin
                    {m_lo, m_hi} = ref_div(m_choice == 4'b1000, m_a, m_b);
                    m_pend = 0;
                end else if (bus.md_busy) begin
                    m_seen = 1'b1;
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", 64'(bus.stall), 64'(bus.issue && m_pend != 0));
            check("hi", 64'(bus.hi), 64'(m_hi));
            check("lo", 64'(bus.lo), 64'(m_lo));
            check("md_choice", 64'(bus.md_choice), 64'((m_pend != 0) ? m_choice : 4'b0000));
            check("md_a", 64'(bus.md_a), 64'(m_a));
            check("md_b", 64'(bus.md_b), 64'(m_b));
            check("md_err", 64'(bus.md_err), 64'(m_abort));
            check("md_rst", 64'(bus.md_rst), 64'(!rst || m_abort));
        end
    end

    task automatic drive(input logic iss, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.issue  = iss;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until accepted; returns just after the accepting edge.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        drive(1'b1, op, a, b);
        #1;
        while (bus.stall && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fails++;
            $display("FAIL issue_wait: stall still %b after %0d cycles, required 0", bus.stall, n);
        end
        tick();
        drive(1'b0, 3'b000, '0, '0);
    endtask

    initial begin
        int cycles;
        int pulses;
        drive(1'b0, 3'b000, '0, '0);
        rst = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        check("rst_hi", 64'(bus.hi), 64'h0);
        check("rst_lo", 64'(bus.lo), 64'h0);
        check("rst_choice", 64'(bus.md_choice), 64'h0);
        check("rst_md_rst", 64'(bus.md_rst), 64'h1);
        check("rst_md_err", 64'(bus.md_err), 64'h0);
        check("rst_stall", 64'(bus.stall), 64'h0);
        rst = 1'b1;
        tick();

        // MULT -3 * 5
        issue_op(3'b001, 32'hFFFF_FFFD, 32'h0000_0005);
        check("mult_choice", 64'(bus.md_choice), 64'h2);
        tick();
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        check("mult_choice_off", 64'(bus.md_choice), 64'h0);

        // MULTU with an MTLO arriving in the MUL cycle
        issue_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002);
        drive(1'b1, 3'b110, 32'hA5A5_A5A5, '0);
        #1;
        check("multu_mtlo_stall", 64'(bus.stall), 64'h1);
        tick();
        check("multu_hi", 64'(bus.hi), 64'h1);
        check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        check("mtlo_accept", 64'(bus.stall), 64'h0);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        check("mtlo_lo", 64'(bus.lo), 64'hA5A5_A5A5);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h1);

        // DIV -7 / 2, unit busy 33 cycles
        u_lat = 33;
        issue_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002);
        cycles = 0;
        while (bus.md_choice == 4'b1000 && cycles < 100) begin
            tick();
            cycles++;
        end
        check("div_choice_cycles", 64'(cycles), 64'd35);
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

        // DIVU 100 / 7 with an MTHI stalled behind it
        u_lat = 10;
        issue_op(3'b100, 32'd100, 32'd7);
        tick();
        tick();
        drive(1'b1, 3'b101, 32'hDEAD_BEEF, '0);
        #1;
        check("mthi_stall", 64'(bus.stall), 64'h1);
        cycles = 0;
        while (bus.stall && cycles < 100) begin
            tick();
            cycles++;
        end
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi_lo_kept", 64'(bus.lo), 64'd14);

        // Reset in the middle of a DIVU
        u_lat = 33;
        issue_op(3'b100, 32'd1000, 32'd3);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("midrst_md_rst", 64'(bus.md_rst), 64'h1);
        tick();
        check("midrst_hi", 64'(bus.hi), 64'h0);
        check("midrst_lo", 64'(bus.lo), 64'h0);
        check("midrst_choice", 64'(bus.md_choice), 64'h0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        check("midrst_no_late_hi", 64'(bus.hi), 64'h0);
        check("midrst_no_late_lo", 64'(bus.lo), 64'h0);

        // Invalid codes in IDLE are ignored
        drive(1'b1, 3'b111, 32'h1234_5678, '0);
        tick();
        drive(1'b1, 3'b000, 32'h1234_5678, '0);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        check("nop_hi", 64'(bus.hi), 64'h0);

        // Timeout: unit never drops busy
        issue_op(3'b101, 32'h1111_1111, '0);
        issue_op(3'b110, 32'h2222_2222, '0);
        u_lat = 1000;
        issue_op(3'b011, 32'd50, 32'd5);
        cycles = 0;
        while (!bus.md_err && cycles < 200) begin
            tick();
            cycles++;
        end
        check("timeout_cycles", 64'(cycles), 64'(TIMEOUT));
        check("timeout_md_rst", 64'(bus.md_rst), 64'h1);
        check("timeout_hi", 64'(bus.hi), 64'h1111_1111);
        check("timeout_lo", 64'(bus.lo), 64'h2222_2222);
        drive(1'b1, 3'b000, '0, '0);
        #1;
        check("timeout_stall", 64'(bus.stall), 64'h0);
        drive(1'b0, 3'b000, '0, '0);
        pulses = 0;
        repeat (60) begin
            tick();
            if (bus.md_err) pulses++;
        end
        check("timeout_single_pulse", 64'(pulses), 64'd0);

        // Unit recovers after the abort
        u_lat = 5;
        issue_op(3'b100, 32'd9, 32'd4);
        repeat (12) tick();
        check("recover_lo", 64'(bus.lo), 64'd2);
        check("recover_hi", 64'(bus.hi), 64'd1);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
